// File: rtl/vproc_mem_req_master.sv
// Bus master for the vicuna simple memory interface: turns a valid/ready
// command stream into single-cycle bus requests and collects the in-order
// bus responses into a valid/ready response stream. Credits bound the number
// of commands in flight so the response FIFO can never overflow.

// Checker: structural invariants of the request master.
module vproc_mem_req_master_chk #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             rsp_push_i,
    input logic             rsp_pop_i,
    input logic [CNT_W-1:0] rsp_cnt_i,
    input logic [CNT_W-1:0] cnt_i
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // A push into a full response FIFO without a simultaneous pop loses data.
    a_rsp_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_push_i && !rsp_pop_i && (rsp_cnt_i == MAX_CNT)));

    // The credit counter never exceeds the configured number of credits.
    a_cnt_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cnt_i <= MAX_CNT));
endmodule

module vproc_mem_req_master #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_we_o,
    output logic        idle_o,
    output logic        spurious_o
);
    localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    // Circular pointer advance for FIFOs whose depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Credit counter and issue-stage registers.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;

    // In-flight tracking with write-tag FIFO.
    logic [CNT_W-1:0] infl_q, infl_d;
    logic             tag_mem_q [MAX_OUTSTANDING];
    logic             tag_mem_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    // Response FIFO.
    logic [31:0]      rsp_rdata_mem_q [MAX_OUTSTANDING];
    logic [31:0]      rsp_rdata_mem_d [MAX_OUTSTANDING];
    logic             rsp_err_mem_q   [MAX_OUTSTANDING];
    logic             rsp_err_mem_d   [MAX_OUTSTANDING];
    logic             rsp_we_mem_q    [MAX_OUTSTANDING];
    logic             rsp_we_mem_d    [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
    logic             spurious_q, spurious_d;

    logic cmd_ready_s, cmd_hs_s, rsp_valid_s, rsp_pop_s, rsp_take_s, tag_head_s;

    assign cmd_ready_s = (cnt_q < MAX_CNT);
    assign cmd_hs_s    = cmd_valid_i & cmd_ready_s;
    assign rsp_valid_s = (rsp_cnt_q != CNT_ZERO);
    assign rsp_pop_s   = rsp_valid_s & rsp_ready_i;
    // A response belongs to a request if one is in flight or one is on the bus now.
    assign rsp_take_s  = mem_rvalid_i & ((infl_q != CNT_ZERO) | req_q);
    // With an empty tag FIFO the only candidate is the request on the bus now.
    assign tag_head_s  = (infl_q == CNT_ZERO) ? we_q : tag_mem_q[tag_rd_q];

    // Credit accounting: handshakes consume a credit, response pops return one.
    always_comb begin
        cnt_d = cnt_q;
        case ({cmd_hs_s, rsp_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Issue stage: capture command fields on handshake, pulse the request next cycle.
    always_comb begin
        req_d = cmd_hs_s;
        if (cmd_hs_s) begin
            addr_d  = cmd_addr_i;
            we_d    = cmd_we_i;
            be_d    = cmd_be_i;
            wdata_d = cmd_wdata_i;
        end else begin
            addr_d  = addr_q;
            we_d    = we_q;
            be_d    = be_q;
            wdata_d = wdata_q;
        end
    end

    // In-flight counter and write-tag FIFO bookkeeping.
    always_comb begin
        infl_d    = infl_q;
        tag_mem_d = tag_mem_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        case ({req_q, rsp_take_s})
            2'b10:   infl_d = infl_q + CNT_ONE;
            2'b01:   infl_d = infl_q - CNT_ONE;
            default: infl_d = infl_q;
        endcase
        if (req_q) begin
            tag_mem_d[tag_wr_q] = we_q;
            tag_wr_d            = ptr_inc(tag_wr_q);
        end else begin
            tag_wr_d = tag_wr_q;
        end
        if (rsp_take_s) begin
            tag_rd_d = ptr_inc(tag_rd_q);
        end else begin
            tag_rd_d = tag_rd_q;
        end
    end

    // Response FIFO push/pop and sticky spurious-response flag.
    always_comb begin
        rsp_rdata_mem_d = rsp_rdata_mem_q;
        rsp_err_mem_d   = rsp_err_mem_q;
        rsp_we_mem_d    = rsp_we_mem_q;
        rsp_wr_d        = rsp_wr_q;
        rsp_rd_d        = rsp_rd_q;
        rsp_cnt_d       = rsp_cnt_q;
        spurious_d      = spurious_q | (mem_rvalid_i & ~rsp_take_s);
        if (rsp_take_s) begin
            rsp_rdata_mem_d[rsp_wr_q] = mem_rdata_i;
            rsp_err_mem_d[rsp_wr_q]   = mem_err_i;
            rsp_we_mem_d[rsp_wr_q]    = tag_head_s;
            rsp_wr_d                  = ptr_inc(rsp_wr_q);
        end else begin
            rsp_wr_d = rsp_wr_q;
        end
        if (rsp_pop_s) begin
            rsp_rd_d = ptr_inc(rsp_rd_q);
        end else begin
            rsp_rd_d = rsp_rd_q;
        end
        case ({rsp_take_s, rsp_pop_s})
            2'b10:   rsp_cnt_d = rsp_cnt_q + CNT_ONE;
            2'b01:   rsp_cnt_d = rsp_cnt_q - CNT_ONE;
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    // Credit counter and issue-stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= CNT_ZERO;
            req_q   <= 1'b0;
            addr_q  <= 32'h0000_0000;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // In-flight counter and tag FIFO storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            infl_q   <= CNT_ZERO;
            tag_wr_q <= {PTR_W{1'b0}};
            tag_rd_q <= {PTR_W{1'b0}};
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                tag_mem_q[i] <= 1'b0;
            end
        end else begin
            infl_q    <= infl_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_mem_q <= tag_mem_d;
        end
    end

    // Response FIFO storage and spurious flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_wr_q   <= {PTR_W{1'b0}};
            rsp_rd_q   <= {PTR_W{1'b0}};
            rsp_cnt_q  <= CNT_ZERO;
            spurious_q <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                rsp_rdata_mem_q[i] <= 32'h0000_0000;
                rsp_err_mem_q[i]   <= 1'b0;
                rsp_we_mem_q[i]    <= 1'b0;
            end
        end else begin
            rsp_wr_q        <= rsp_wr_d;
            rsp_rd_q        <= rsp_rd_d;
            rsp_cnt_q       <= rsp_cnt_d;
            spurious_q      <= spurious_d;
            rsp_rdata_mem_q <= rsp_rdata_mem_d;
            rsp_err_mem_q   <= rsp_err_mem_d;
            rsp_we_mem_q    <= rsp_we_mem_d;
        end
    end

    assign cmd_ready_o = cmd_ready_s;
    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rsp_valid_o = rsp_valid_s;
    assign rsp_rdata_o = rsp_rdata_mem_q[rsp_rd_q];
    assign rsp_err_o   = rsp_err_mem_q[rsp_rd_q];
    assign rsp_we_o    = rsp_we_mem_q[rsp_rd_q];
    assign idle_o      = (cnt_q == CNT_ZERO);
    assign spurious_o  = spurious_q;

    vproc_mem_req_master_chk #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rsp_push_i (rsp_take_s),
        .rsp_pop_i  (rsp_pop_s),
        .rsp_cnt_i  (rsp_cnt_q),
        .cnt_i      (cnt_q)
    );
endmodule

// File: tb/tb_vproc_mem_req_master.sv
// Randomized and directed bench for vproc_mem_req_master with a latency
// programmable bus memory and an in-order transaction-level reference model.
module tb_vproc_mem_req_master;
    localparam int MAXO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i = 32'h0;
    logic        cmd_we_i = 1'b0;
    logic [3:0]  cmd_be_i = 4'h0;
    logic [31:0] cmd_wdata_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic        mem_err_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_we_o;
    logic        idle_o;
    logic        spurious_o;

    vproc_mem_req_master #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o), .idle_o(idle_o), .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Initial memory contents shared by the bus model and the reference model.
    function automatic logic [31:0] init_word(input int idx);
        logic [31:0] w;
        if (idx == 32'h40) w = 32'hDEAD_BEEF;       // byte address 0x100
        else if (idx == 32'h80) w = 32'hFFFF_FFFF;  // byte address 0x200
        else w = (32'(idx) * 32'h0101_0101) ^ 32'h5A5A_0000;
        return w;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- bus memory model (latency bus_lat, in order) ----------------
    typedef struct { int due; logic err; logic [31:0] rdata; } bus_rsp_t;
    bus_rsp_t    bus_q[$];
    logic [31:0] bus_mem [1024];
    bit          bus_init = 1'b0;
    int          bus_lat = 1;
    logic        inject_spur = 1'b0;

    always @(negedge clk_i) begin
        bus_rsp_t r;
        if (!bus_init) begin
            for (int i = 0; i < 1024; i++) bus_mem[i] = init_word(i);
            bus_init = 1'b1;
        end
        if (mem_req_o) begin
            r.due = cyc + bus_lat;
            r.err = (mem_addr_o >= 32'h1000);
            r.rdata = 32'h0;
            if (!r.err) begin
                if (mem_we_o)
                    bus_mem[mem_addr_o[11:2]] = merge_be(bus_mem[mem_addr_o[11:2]], mem_wdata_o, mem_be_o);
                else
                    r.rdata = bus_mem[mem_addr_o[11:2]];
            end
            bus_q.push_back(r);
        end
        if (inject_spur) begin
            mem_rvalid_i = 1'b1; mem_err_i = 1'b0; mem_rdata_i = 32'hBAD0_BAD0;
        end else if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
            r = bus_q.pop_front();
            mem_rvalid_i = 1'b1; mem_err_i = r.err; mem_rdata_i = r.rdata;
        end else begin
            mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
        end
    end

    // ---------------- transaction-level reference model and monitor ----------------
    typedef struct { logic we; logic err; logic [31:0] rdata; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [1024];
    bit          ref_init = 1'b0;
    int          outst = 0, hs_total = 0, hs_cyc = 0, pop_total = 0;
    int          req_run = 0, pop_run = 0;
    logic        prev_hs = 1'b0, prev_req = 1'b0, prev_pop = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
    logic        prev_we = 1'b0;
    logic [3:0]  prev_be = 4'h0;

    always @(negedge clk_i) begin
        exp_t e;
        logic hs, pop;
        if (!ref_init) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (!rst_ni) begin
            exp_q.delete();
            outst = 0; prev_hs = 1'b0; prev_req = 1'b0; prev_pop = 1'b0;
        end else begin
            check_val("cmd_ready", 32'(cmd_ready_o), 32'(outst < MAXO));
            check_val("idle", 32'(idle_o), 32'(outst == 0));
            check_val("mem_req", 32'(mem_req_o), 32'(prev_hs));
            if (prev_hs) begin
                check_val("mem_addr", mem_addr_o, prev_addr);
                check_val("mem_we", 32'(mem_we_o), 32'(prev_we));
                check_val("mem_be", 32'(mem_be_o), 32'(prev_be));
                check_val("mem_wdata", mem_wdata_o, prev_wdata);
            end
            req_run = mem_req_o ? (prev_req ? req_run + 1 : 1) : req_run;
            prev_req = mem_req_o;
            if (rsp_valid_o) check_val("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            pop = rsp_valid_o && rsp_ready_i;
            if (pop && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("rsp_we", 32'(rsp_we_o), 32'(e.we));
                check_val("rsp_err", 32'(rsp_err_o), 32'(e.err));
                if (!e.we) check_val("rsp_rdata", rsp_rdata_o, e.rdata);
                outst--;
                pop_total++;
            end
            pop_run = pop ? (prev_pop ? pop_run + 1 : 1) : pop_run;
            prev_pop = pop;
            hs = cmd_valid_i && cmd_ready_o;
            if (hs) begin
                e.we = cmd_we_i;
                e.err = (cmd_addr_i >= 32'h1000);
                e.rdata = 32'h0;
                if (!e.err) begin
                    if (cmd_we_i)
                        ref_mem[cmd_addr_i[11:2]] = merge_be(ref_mem[cmd_addr_i[11:2]], cmd_wdata_i, cmd_be_i);
                    else
                        e.rdata = ref_mem[cmd_addr_i[11:2]];
                end
                exp_q.push_back(e);
                outst++; hs_total++; hs_cyc = cyc;
            end
            prev_hs = hs; prev_addr = cmd_addr_i; prev_we = cmd_we_i;
            prev_be = cmd_be_i; prev_wdata = cmd_wdata_i;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        int n = 0;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_be_i = be; cmd_wdata_i = wd;
        do begin @(negedge clk_i); n++; end while (!cmd_ready_o && n < 50);
        if (!cmd_ready_o) check_val("send_timeout", 32'(n), 32'd0);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        do begin @(negedge clk_i); n++; end while (!rsp_valid_o && n < 60);
        if (!rsp_valid_o) check_val("rsp_timeout", 32'(n), 32'd0);
        lat = cyc - hs_cyc;
    endtask

    task automatic pop_one();
        @(posedge clk_i); #1; rsp_ready_i = 1'b1;
        @(posedge clk_i); #1; rsp_ready_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk_i); #1; cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
        do begin @(negedge clk_i); n++; end while (!(idle_o && bus_q.size() == 0) && n < 300);
        check_val("drain_idle", 32'(idle_o), 32'd1);
        @(posedge clk_i); #1; rsp_ready_i = 1'b0;
    endtask

    task automatic check_reset_vals();
        check_val("rst_mem_req", 32'(mem_req_o), 32'd0);
        check_val("rst_mem_we", 32'(mem_we_o), 32'd0);
        check_val("rst_mem_be", 32'(mem_be_o), 32'd0);
        check_val("rst_mem_addr", mem_addr_o, 32'd0);
        check_val("rst_mem_wdata", mem_wdata_o, 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check_val("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check_val("rst_rsp_we", 32'(rsp_we_o), 32'd0);
        check_val("rst_spurious", 32'(spurious_o), 32'd0);
        check_val("rst_idle", 32'(idle_o), 32'd1);
        check_val("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, base, pbase, sent, n;
        logic had;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); check_reset_vals();
        @(posedge clk_i); #1; rst_ni = 1'b1;

        // Single read, L=1.
        bus_lat = 1;
        send(32'h100, 1'b0, 4'hF, 32'h0);
        wait_rsp(lat);
        check_val("rd_latency_l1", 32'(lat), 32'd3);
        check_val("rd_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        check_val("rd_err", 32'(rsp_err_o), 32'd0);
        check_val("rd_we", 32'(rsp_we_o), 32'd0);
        pop_one();
        @(negedge clk_i); check_val("rd_idle_after", 32'(idle_o), 32'd1);

        // Write with byte enables, then read back.
        send(32'h200, 1'b1, 4'b0101, 32'h1122_3344);
        send(32'h200, 1'b0, 4'hF, 32'h0);
        wait_rsp(lat);
        check_val("wr_rsp_we", 32'(rsp_we_o), 32'd1);
        pop_one();
        wait_rsp(lat);
        check_val("rb_rdata", rsp_rdata_o, 32'hFF22_FF44);
        check_val("rb_we", 32'(rsp_we_o), 32'd0);
        pop_one();

        // Streaming 16 reads, L=1, always ready.
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1; cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0;
        base = hs_total; pbase = pop_total; n = 0;
        begin
            int first_hs = 0, last_hs = 0;
            while (n < 16 && cyc < 5000) begin
                @(negedge clk_i);
                if (cmd_ready_o) begin
                    if (n == 0) first_hs = cyc;
                    last_hs = cyc; n++;
                end
                @(posedge clk_i); #1;
                cmd_addr_i = 32'(n) << 2;
                if (n == 16) cmd_valid_i = 1'b0;
            end
            check_val("stream_hs_span", 32'(last_hs - first_hs), 32'd15);
        end
        drain();
        check_val("stream_hs", 32'(hs_total - base), 32'd16);
        check_val("stream_pops", 32'(pop_total - pbase), 32'd16);
        check_val("stream_req_run", 32'(req_run), 32'd16);
        check_val("stream_pop_run", 32'(pop_run), 32'd16);

        // Backpressure: credits run out after MAXO handshakes.
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0; cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h40;
        base = hs_total;
        repeat (12) @(negedge clk_i);
        check_val("bp_hs", 32'(hs_total - base), 32'(MAXO));
        check_val("bp_ready_low", 32'(cmd_ready_o), 32'd0);
        pop_one();
        @(negedge clk_i); check_val("bp_ready_back", 32'(cmd_ready_o), 32'd1);
        repeat (8) @(negedge clk_i);
        check_val("bp_one_more", 32'(hs_total - base), 32'(MAXO + 1));
        drain();

        // Error response with L=3.
        bus_lat = 3;
        send(32'h0010_0000, 1'b0, 4'hF, 32'h0);
        wait_rsp(lat);
        check_val("err_latency_l3", 32'(lat), 32'd5);
        check_val("err_flag", 32'(rsp_err_o), 32'd1);
        pop_one();
        drain();

        // Spurious response while idle.
        check_val("spur_before", 32'(spurious_o), 32'd0);
        @(posedge clk_i); #1; inject_spur = 1'b1;
        @(posedge clk_i); #1; inject_spur = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("spur_set", 32'(spurious_o), 32'd1);
        check_val("spur_no_rsp", 32'(rsp_valid_o), 32'd0);
        check_val("spur_idle", 32'(idle_o), 32'd1);

        // Reset with three requests in flight; late responses become spurious.
        bus_lat = 8;
        send(32'h10, 1'b0, 4'hF, 32'h0);
        send(32'h14, 1'b0, 4'hF, 32'h0);
        send(32'h18, 1'b0, 4'hF, 32'h0);
        check_val("mid_busy", 32'(idle_o), 32'd0);
        @(posedge clk_i); #1; rst_ni = 1'b0;
        @(negedge clk_i); check_reset_vals();
        @(posedge clk_i); #1; rst_ni = 1'b1;
        repeat (15) @(negedge clk_i);
        check_val("late_spurious", 32'(spurious_o), 32'd1);
        check_val("late_no_rsp", 32'(rsp_valid_o), 32'd0);
        check_val("late_idle", 32'(idle_o), 32'd1);
        check_val("late_bus_drained", 32'(bus_q.size()), 32'd0);

        // Randomized traffic over several bus latencies.
        for (int round = 0; round < 4; round++) begin
            int guard = 0;
            bus_lat = 1 + round;
            sent = 0; had = 1'b0;
            while (sent < 30 && guard < 2000) begin
                @(posedge clk_i); #1; guard++;
                if (!cmd_valid_i || had) begin
                    int w;
                    cmd_valid_i = ($urandom_range(0, 3) != 0);
                    cmd_we_i = 1'($urandom_range(0, 1));
                    w = $urandom_range(0, 63);
                    cmd_addr_i = ($urandom_range(0, 7) == 0) ? (32'h0010_0000 + (32'(w) << 2)) : (32'(w) << 2);
                    cmd_be_i = 4'($urandom_range(0, 15));
                    cmd_wdata_i = $urandom;
                end
                rsp_ready_i = ($urandom_range(0, 3) != 0);
                @(negedge clk_i);
                had = cmd_valid_i && cmd_ready_o;
                if (had) sent++;
            end
            check_val("rand_progress", 32'(sent), 32'd30);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
